// File: rtl/rotary_level_if.sv
// Encoder/bargraph signal bundle: raw quadrature and enable in, level, bargraph and pulses out.
interface rotary_level_if #(
  parameter int LEVELS = 8
) ();
  localparam int LW = $clog2(LEVELS + 1);

  logic              quad_a;
  logic              quad_b;
  logic              enable;
  logic [LW-1:0]     level;
  logic [LEVELS-1:0] bargraph;
  logic              step_up;
  logic              step_down;
  logic              error;

  modport master (
    output quad_a, quad_b, enable,
    input  level, bargraph, step_up, step_down, error
  );

  modport slave (
    input  quad_a, quad_b, enable,
    output level, bargraph, step_up, step_down, error
  );
endinterface

// File: rtl/rotary_level_ctrl.sv
// Rotary encoder front end: sync + debounce per phase, x4 quadrature decode,
// detent accumulator and saturating thermometer-coded level register.
module rotary_level_ctrl #(
  parameter int LEVELS          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  rotary_level_if.slave bus
);
  localparam int LW = $clog2(LEVELS + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(LEVELS);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        prime_cnt_reg, prime_cnt_next;
  logic              prime_done;

  logic [1:0]        raw;
  logic [1:0]        sync2_vec;
  logic [1:0]        stable_vec;
  logic [1:0]        prev_reg;

  logic signed [2:0] acc_reg, acc_next;
  logic [LW-1:0]     level_reg, level_next;
  logic [LEVELS-1:0] bargraph_reg, bargraph_next;
  logic              step_up_reg, step_up_next;
  logic              step_down_reg, step_down_next;
  logic              error_reg, error_next;

  logic [1:0]        phase_diff;
  logic              move_cw, move_ccw, move_bad;

  assign raw        = {bus.quad_a, bus.quad_b};
  assign prime_done = (state_reg == PRIME) && (prime_cnt_reg == 2'd2);

  // Per-phase synchronizer and debouncer; index 1 is A, index 0 is B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_phase
    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_reg  <= 1'b0;
        sync2_reg  <= 1'b0;
        stable_reg <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        sync1_reg <= raw[gi];
        sync2_reg <= sync1_reg;
        if (state_reg == PRIME) begin
          cnt_reg <= '0;
          if (prime_done) begin
            stable_reg <= sync2_reg;
          end
        end else if (sync2_reg == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign sync2_vec[gi]  = sync2_reg;
    assign stable_vec[gi] = stable_reg;
  end

  // Position of a {A,B} pair along the clockwise cycle 00->01->11->10.
  function automatic logic [1:0] phase_index(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Modulo-4 distance travelled: 1 forward, 3 backward, 2 means both phases flipped.
  assign phase_diff = phase_index(stable_vec) - phase_index(prev_reg);
  assign move_cw    = (state_reg == RUN) && (phase_diff == 2'd1);
  assign move_ccw   = (state_reg == RUN) && (phase_diff == 2'd3);
  assign move_bad   = (state_reg == RUN) && (phase_diff == 2'd2);

  always_comb begin
    state_next     = state_reg;
    prime_cnt_next = prime_cnt_reg;
    acc_next       = acc_reg;
    level_next     = level_reg;
    step_up_next   = 1'b0;
    step_down_next = 1'b0;
    error_next     = 1'b0;

    case (state_reg)
      PRIME: begin
        prime_cnt_next = prime_cnt_reg + 2'd1;
        if (prime_done) begin
          state_next     = RUN;
          prime_cnt_next = 2'd0;
        end
      end
      RUN: begin
        error_next = move_bad;
        if (!bus.enable) begin
          acc_next = 3'sd0;
        end else if (move_cw) begin
          if (acc_reg == 3'sd3) begin
            acc_next     = 3'sd0;
            step_up_next = 1'b1;
          end else begin
            acc_next = acc_reg + 3'sd1;
          end
        end else if (move_ccw) begin
          if (acc_reg == -3'sd3) begin
            acc_next       = 3'sd0;
            step_down_next = 1'b1;
          end else begin
            acc_next = acc_reg - 3'sd1;
          end
        end

        if (step_up_next && (level_reg != LEVEL_MAX)) begin
          level_next = level_reg + 1'b1;
        end else if (step_down_next && (level_reg != '0)) begin
          level_next = level_reg - 1'b1;
        end
      end
      default: begin
        state_next     = PRIME;
        prime_cnt_next = 2'd0;
      end
    endcase
  end

  // Thermometer code from the next level so bargraph and level register together.
  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_therm
    assign bargraph_next[gi] = (level_next > LW'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PRIME;
      prime_cnt_reg <= 2'd0;
      prev_reg      <= 2'b00;
      acc_reg       <= 3'sd0;
      level_reg     <= '0;
      bargraph_reg  <= '0;
      step_up_reg   <= 1'b0;
      step_down_reg <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prime_cnt_reg <= prime_cnt_next;
      acc_reg       <= acc_next;
      level_reg     <= level_next;
      bargraph_reg  <= bargraph_next;
      step_up_reg   <= step_up_next;
      step_down_reg <= step_down_next;
      error_reg     <= error_next;
      if (prime_done) begin
        prev_reg <= sync2_vec;
      end else if (state_reg == RUN) begin
        prev_reg <= stable_vec;
      end
    end
  end

  assign bus.level     = level_reg;
  assign bus.bargraph  = bargraph_reg;
  assign bus.step_up   = step_up_reg;
  assign bus.step_down = step_down_reg;
  assign bus.error     = error_reg;
endmodule
